clmul16_karatsuba_seq: RTL and testbench

Sequencer that computes a 16x16-bit carry-less (GF(2) polynomial) product by time-sharing one external 8x8 carry-less multiplier (15-bit product, pure AND/XOR array). It applies the three Karatsuba sub-products in turn, captures each one, and combines them into a 31-bit result. It sits between a requester using a valid/ready handshake and the shared 8-bit multiplier instance, and drives that multiplier's operand ports.

---
 rtl/clmul16_karatsuba_seq.sv | 114 +++++++++++
 tb/tb_clmul16_karatsuba_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clmul16_karatsuba_seq.sv
// 16x16 carry-less multiplier built from three Karatsuba sub-products on one
// shared 8x8 carry-less multiplier, with valid/ready handshakes on both sides.
module clmul16_karatsuba_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_y,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [14:0] mul_y
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DONE} state_t;

  state_t      state;
  logic [7:0]  a_lo, a_hi, b_lo, b_hi;
  logic [14:0] p0, p1, p2;
  logic        cnt;
  logic        last;
  logic [14:0] mid;

  assign in_ready = (state == IDLE);
  assign last     = (cnt == 1'(MUL_LAT));

  // Result is a pure function of the captured sub-products, so it holds
  // steady for as long as the consumer stalls in DONE.
  assign mid   = p1 ^ p0 ^ p2;
  assign out_y = {p2, 16'h0000} ^ {8'h00, mid, 8'h00} ^ {16'h0000, p0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_lo      <= '0;
      a_hi      <= '0;
      b_lo      <= '0;
      b_hi      <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      cnt       <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lo  <= in_a[7:0];
            a_hi  <= in_a[15:8];
            b_lo  <= in_b[7:0];
            b_hi  <= in_b[15:8];
            mul_a <= in_a[7:0];
            mul_b <= in_b[7:0];
            cnt   <= 1'b0;
            busy  <= 1'b1;
            state <= MUL0;
          end
        end
        MUL0: begin
          if (last) begin
            p0    <= mul_y;
            mul_a <= a_hi;
            mul_b <= b_hi;
            cnt   <= 1'b0;
            state <= MUL1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL1: begin
          if (last) begin
            p2    <= mul_y;
            mul_a <= a_lo ^ a_hi;
            mul_b <= b_lo ^ b_hi;
            cnt   <= 1'b0;
            state <= MUL2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL2: begin
          if (last) begin
            p1        <= mul_y;
            mul_a     <= '0;
            mul_b     <= '0;
            cnt       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clmul16_karatsuba_seq.sv
// Bench for clmul16_karatsuba_seq: one instance per multiplier latency, each
// paired with a behavioural 8x8 carry-less multiplier of matching latency.
module tb_clmul16_karatsuba_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       in_valid = '0;
  logic [1:0]       out_ready = '0;
  logic [1:0][15:0] in_a = '0;
  logic [1:0][15:0] in_b = '0;
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [1:0]       busy;
  wire  [1:0][30:0] out_y;
  wire  [1:0][7:0]  mul_a;
  wire  [1:0][7:0]  mul_b;
  wire  [1:0][14:0] mul_y;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] seq_a [16];
  logic [7:0] seq_b [16];

  function automatic logic [14:0] clmul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) acc ^= 15'(a) << i;
    return acc;
  endfunction

  function automatic logic [30:0] ref_clmul(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) acc ^= 31'(a) << i;
    return acc;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    clmul16_karatsuba_seq #(.MUL_LAT(gi)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .in_a(in_a[gi]), .in_b(in_b[gi]),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .out_y(out_y[gi]), .busy(busy[gi]),
      .mul_a(mul_a[gi]), .mul_b(mul_b[gi]), .mul_y(mul_y[gi])
    );
    if (gi == 0) begin : g_comb
      assign mul_y[gi] = clmul8(mul_a[gi], mul_b[gi]);
    end else begin : g_reg
      logic [14:0] y_q = '0;
      always @(posedge clk) y_q <= clmul8(mul_a[gi], mul_b[gi]);
      assign mul_y[gi] = y_q;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge right after the accept edge.
  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b);
    in_a[d] = a;
    in_b[d] = b;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 20 && !in_ready[d]; i++) @(negedge clk);
    check("accept_ready", 32'(in_ready[d]), 1);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // lat counts cycles after the accept edge; cycle 1 is the first one.
  task automatic wait_valid(input int d, output int lat);
    lat = 1;
    while (1) begin
      if (lat < 16) begin
        seq_a[lat] = mul_a[d];
        seq_b[lat] = mul_b[d];
      end
      if (out_valid[d] || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    check("out_valid_rise", 32'(out_valid[d]), 1);
  endtask

  task automatic run_one(input int d, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [30:0] exp_y);
    int lat;
    out_ready[d] = 1'b1;
    send(d, a, b);
    wait_valid(d, lat);
    check("latency", lat, exp_lat);
    check("out_y", 32'(out_y[d]), 32'(exp_y));
    check("out_y_ref", 32'(out_y[d]), 32'(ref_clmul(a, b)));
    $display("LAT%0d a=%h b=%h y=%h lat=%0d", d, a, b, out_y[d], lat);
    @(negedge clk);
    check("back_idle_valid", 32'(out_valid[d]), 0);
    check("back_idle_ready", 32'(in_ready[d]), 1);
  endtask

  task automatic run_random(input int d, input int n);
    logic [30:0] exp_q[$];
    logic [30:0] e;
    int sent, got, cyc;
    logic acc_prev;
    sent = 0; got = 0; cyc = 0; acc_prev = 1'b0;
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    while (got < n && cyc < 40 * n) begin
      if (acc_prev) in_valid[d] = 1'b0;
      if (in_valid[d] || (sent < n && $urandom_range(0, 2) != 0)) begin
        // Data may change freely until the accepting edge.
        in_a[d] = 16'($urandom);
        in_b[d] = 16'($urandom);
        in_valid[d] = 1'b1;
      end
      out_ready[d] = ($urandom_range(0, 3) != 0);
      acc_prev = in_valid[d] & in_ready[d];
      if (acc_prev) begin
        exp_q.push_back(ref_clmul(in_a[d], in_b[d]));
        sent++;
      end
      if (out_valid[d] && out_ready[d]) begin
        if (exp_q.size() == 0) begin
          check("rand_extra", 32'(out_valid[d]), 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_y", 32'(out_y[d]), 32'(e));
          $display("LAT%0d rand #%0d y=%h", d, got, out_y[d]);
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("rand_count", got, n);
    check("rand_pending", exp_q.size(), 0);
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [30:0] exp_y;
    logic seen;

    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 1);
      check("rst_out_valid", 32'(out_valid[d]), 0);
      check("rst_busy", 32'(busy[d]), 0);
      check("rst_out_y", 32'(out_y[d]), 0);
      check("rst_mul_a", 32'(mul_a[d]), 0);
      check("rst_mul_b", 32'(mul_b[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product and operand sequence to the shared multiplier.
    run_one(0, 16'h0003, 16'h0003, 4, 31'h00000005);
    check("seq1_a", 32'(seq_a[1]), 32'h03);
    check("seq1_b", 32'(seq_b[1]), 32'h03);
    check("seq2_a", 32'(seq_a[2]), 32'h00);
    check("seq2_b", 32'(seq_b[2]), 32'h00);
    check("seq3_a", 32'(seq_a[3]), 32'h03);
    check("seq3_b", 32'(seq_b[3]), 32'h03);
    check("seq_done_a", 32'(seq_a[4]), 32'h00);

    run_one(0, 16'hFFFF, 16'hFFFF, 4, 31'h55555555);
    run_one(0, 16'h8000, 16'h8000, 4, 31'h40000000);
    run_one(0, 16'h0100, 16'h0100, 4, 31'h00010000);

    // Identity with a registered multiplier.
    run_one(1, 16'hA5C3, 16'h0001, 7, 31'h0000A5C3);
    check("lat1_seq_a1", 32'(seq_a[1]), 32'hC3);
    check("lat1_seq_a3", 32'(seq_a[3]), 32'hA5);
    check("lat1_seq_a5", 32'(seq_a[5]), 32'h66);
    check("lat1_seq_b5", 32'(seq_b[5]), 32'h01);

    // Backpressure: result holds, extra requests ignored.
    out_ready[0] = 1'b0;
    send(0, 16'h1357, 16'h2468);
    wait_valid(0, lat);
    exp_y = ref_clmul(16'h1357, 16'h2468);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = (i % 2 == 0);
      in_a[0] = 16'($urandom);
      in_b[0] = 16'($urandom);
      @(negedge clk);
      check("bp_out_y", 32'(out_y[0]), 32'(exp_y));
      check("bp_out_valid", 32'(out_valid[0]), 1);
      check("bp_in_ready", 32'(in_ready[0]), 0);
    end
    $display("LAT0 backpressure y=%h", out_y[0]);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid[0]), 0);
    check("bp_release_ready", 32'(in_ready[0]), 1);
    run_one(0, 16'hBEEF, 16'h1234, 4, ref_clmul(16'hBEEF, 16'h1234));

    // Asynchronous reset during MUL1.
    send(0, 16'hF00F, 16'h0FF0);
    @(negedge clk);
    check("pre_rst_mul_a", 32'(mul_a[0]), 32'hF0);
    check("pre_rst_mul_b", 32'(mul_b[0]), 32'h0F);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_valid", 32'(out_valid[0]), 0);
    check("mid_rst_ready", 32'(in_ready[0]), 1);
    check("mid_rst_mul_a", 32'(mul_a[0]), 0);
    check("mid_rst_mul_b", 32'(mul_b[0]), 0);
    check("mid_rst_out_y", 32'(out_y[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= out_valid[0];
      @(negedge clk);
    end
    check("rst_no_valid", 32'(seen), 0);
    $display("LAT0 reset mid-operation done");
    run_one(0, 16'h1234, 16'h5678, 4, ref_clmul(16'h1234, 16'h5678));

    // Randomized sweep with random request gaps and consumer stalls.
    run_random(0, 1500);
    run_random(1, 1500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
